memory_load_aligner: RTL and testbench

- Load-side counterpart of the store-side memory mutator: it issues word-aligned reads to data memory and extracts the addressed byte, halfword or word from the returned word.
- Extracted data is sign- or zero-extended and returned to the core through a valid/ready channel.
- Tracks up to DEPTH outstanding loads in an in-order metadata/data buffer. It sits between the LSU load path and the memory read port.

---
 rtl/mem_access_pkg.sv | 39 +++
 rtl/memory_load_aligner_if.sv | 31 +++
 rtl/memory_load_aligner_load_extract.sv | 29 ++
 rtl/memory_load_aligner.sv | 100 ++++++++++
 tb/tb_memory_load_aligner.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared load/store memory access definitions: size encodings, load buffer entry
// and the byte-enable rule both sides use to decide which offsets are legal.
package mem_access_pkg;

    typedef enum logic [1:0] {
        ACC_INV = 2'b00,
        ACC_B   = 2'b01,
        ACC_H   = 2'b10,
        ACC_W   = 2'b11
    } acc_size_e;

    typedef struct packed {
        acc_size_e   size;
        logic        sign;
        logic [1:0]  off;
        logic        misaligned;
        logic        misaccess;
        logic [31:0] data;
        logic        done;
    } load_entry_t;

    function automatic logic is_misaligned(acc_size_e size, logic [1:0] off);
        return (size == ACC_H && off == 2'd3) || (size == ACC_W && off != 2'd0);
    endfunction

    // Faulting accesses (misaligned or invalid size) touch no lanes.
    function automatic logic [3:0] byte_en(acc_size_e size, logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            ACC_B:   be = 4'b0001 << off;
            ACC_H:   be = (off == 2'd3) ? 4'b0000 : (4'b0011 << off);
            ACC_W:   be = (off == 2'd0) ? 4'b1111 : 4'b0000;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/memory_load_aligner_if.sv
// Request, memory-read and response channels of the load aligner.
// The slave modport is the aligner's view; master is the LSU/memory side.
interface memory_load_aligner_if #(parameter int AW = 32);
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_access_size;
    logic          req_sign;
    logic [AW-1:0] req_addr;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_byte_en;
    logic [31:0]   mem_rdata;
    logic          mem_rvalid;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic          rsp_misaligned;
    logic          rsp_misaccess;

    modport slave (
        input  req_valid, req_access_size, req_sign, req_addr, mem_rdata, mem_rvalid, rsp_ready,
        output req_ready, mem_rd_en, mem_addr, mem_byte_en, rsp_valid, rsp_data,
               rsp_misaligned, rsp_misaccess
    );

    modport master (
        output req_valid, req_access_size, req_sign, req_addr, mem_rdata, mem_rvalid, rsp_ready,
        input  req_ready, mem_rd_en, mem_addr, mem_byte_en, rsp_valid, rsp_data,
               rsp_misaligned, rsp_misaccess
    );
endinterface

// File: rtl/memory_load_aligner_load_extract.sv
// Pulls the addressed byte/half/word out of a returned memory word and extends it.
// Faulting loads return zero.
module load_extract
    import mem_access_pkg::*;
(
    input  acc_size_e   size,
    input  logic        sign,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    input  logic        misaligned,
    input  logic        misaccess,
    output logic [31:0] rsp_data
);
    logic [31:0] sh;

    assign sh = data >> {off, 3'b000};

    always_comb begin
        rsp_data = '0;
        if (!(misaligned || misaccess)) begin
            case (size)
                ACC_B:   rsp_data = {{24{sign & sh[7]}}, sh[7:0]};
                ACC_H:   rsp_data = {{16{sign & sh[15]}}, sh[15:0]};
                ACC_W:   rsp_data = data;
                default: rsp_data = '0;
            endcase
        end
    end
endmodule

// File: rtl/memory_load_aligner.sv
// In-order load aligner: issues word reads, buffers up to DEPTH loads, returns extended data.
// MEMORY_LOAD_ALIGNER_FWD_EN forwards mem_rdata straight to the response when the head returns.
module memory_load_aligner
    import mem_access_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    memory_load_aligner_if.slave    bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    load_entry_t   ent [DEPTH];
    logic [PW-1:0] wr, ret, rd;
    logic [IW-1:0] wr_i, ret_i, rd_i;
    acc_size_e     req_size;
    logic [1:0]    req_off;
    logic          full, issue, ret_ok, fwd, pop;
    load_entry_t   head;
    logic [31:0]   ext_data;

    assign wr_i     = wr[IW-1:0];
    assign ret_i    = ret[IW-1:0];
    assign rd_i     = rd[IW-1:0];
    assign req_size = acc_size_e'(bus.req_access_size);
    assign req_off  = bus.req_addr[1:0];

    assign full          = (wr - rd) == PW'(DEPTH);
    assign bus.req_ready = !full;
    assign issue         = bus.req_valid && !full;

    assign bus.mem_rd_en   = issue;
    assign bus.mem_addr    = {bus.req_addr[AW-1:2], 2'b00};
    assign bus.mem_byte_en = byte_en(req_size, req_off);

    // Returns with nothing outstanding are leftovers from before a reset.
    assign ret_ok = bus.mem_rvalid && (ret != wr);
    assign head   = ent[rd_i];

`ifdef MEMORY_LOAD_ALIGNER_FWD_EN
    assign fwd           = ret_ok && (ret == rd);
    assign ext_data      = fwd ? bus.mem_rdata : head.data;
    assign bus.rsp_valid = (head.done && (rd != ret)) || fwd;
`else
    assign fwd           = 1'b0;
    assign ext_data      = head.data;
    assign bus.rsp_valid = head.done && (rd != ret);
`endif

    assign pop = bus.rsp_valid && bus.rsp_ready;

    load_extract u_extract (
        .size       (head.size),
        .sign       (head.sign),
        .off        (head.off),
        .data       (ext_data),
        .misaligned (head.misaligned),
        .misaccess  (head.misaccess),
        .rsp_data   (bus.rsp_data)
    );

    assign bus.rsp_misaligned = head.misaligned;
    assign bus.rsp_misaccess  = head.misaccess;

    // Issue, return and pop slots never alias: issue is blocked when full and
    // the return slot only equals the issue slot when nothing is outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr  <= '0;
            ret <= '0;
            rd  <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else begin
            if (issue) begin
                ent[wr_i] <= '{size:       req_size,
                               sign:       bus.req_sign,
                               off:        req_off,
                               misaligned: is_misaligned(req_size, req_off),
                               misaccess:  (req_size == ACC_INV),
                               data:       32'h0,
                               done:       1'b0};
                wr <= wr + 1'b1;
            end
            if (ret_ok) begin
                if (!(fwd && bus.rsp_ready)) begin
                    ent[ret_i].data <= bus.mem_rdata;
                    ent[ret_i].done <= 1'b1;
                end
                ret <= ret + 1'b1;
            end
            if (pop) begin
                if (!fwd) ent[rd_i].done <= 1'b0;
                rd <= rd + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_memory_load_aligner.sv
// Randomized bench for memory_load_aligner with an in-order load model and memory model.
// Honours MEMORY_LOAD_ALIGNER_FWD_EN for the zero-latency response expectation.
module tb_memory_load_aligner;
    import mem_access_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memory_load_aligner_if #(.AW(AW)) bus();

    memory_load_aligner #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        mal;
        logic        mac;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] mq_dat[$];
    int          mq_cyc[$];
    int          n_ret, cyc, n_chk, n_pass, n_issued;

    bit          drv_req, drv_sign, want_ret, want_ready, stale;
    logic [31:0] drv_addr, drv_rdata;
    int          drv_size;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    endtask

    // Reference: pick the addressed bytes arithmetically and extend by value range.
    function automatic rsp_t model(input logic [31:0] addr, input int size, input bit sign,
                                   input logic [31:0] rdata);
        rsp_t   r;
        longint v;
        int     off;
        off = int'(addr % 4);
        r.data = 32'h0; r.mal = 1'b0; r.mac = 1'b0;
        if (size == 0) r.mac = 1'b1;
        else if (size == 1) begin
            v = longint'(rdata / (32'd1 << (8 * off))) % 256;
            if (sign && v >= 128) v -= 256;
            r.data = 32'(v);
        end else if (size == 2) begin
            if (off == 3) r.mal = 1'b1;
            else begin
                v = longint'(rdata / (32'd1 << (8 * off))) % 65536;
                if (sign && v >= 32768) v -= 65536;
                r.data = 32'(v);
            end
        end else begin
            if (off != 0) r.mal = 1'b1;
            else r.data = rdata;
        end
        return r;
    endfunction

    function automatic logic [3:0] model_be(input int size, input int off);
        int be;
        be = 0;
        if (size == 1) be = 1 << off;
        else if (size == 2 && off < 3) be = 3 << off;
        else if (size == 3 && off == 0) be = 15;
        return 4'(be);
    endfunction

    task automatic cycle();
        bit   ret_now, mret, popped, issued, exp_rv;
        rsp_t e;
        @(negedge clk);
        bus.req_valid       = drv_req;
        bus.req_addr        = drv_addr;
        bus.req_access_size = 2'(drv_size);
        bus.req_sign        = drv_sign;
        mret    = want_ret && mq_dat.size() > 0 && mq_cyc[0] < cyc;
        ret_now = mret || stale;
        bus.mem_rvalid = ret_now;
        bus.mem_rdata  = mret ? mq_dat[0] : $urandom;
        bus.rsp_ready  = want_ready;
        #1;
        chk("req_ready", bus.req_ready, exp_q.size() < DEPTH);
        exp_rv = n_ret > 0;
`ifdef MEMORY_LOAD_ALIGNER_FWD_EN
        if (mret && n_ret == 0) exp_rv = 1'b1;
`endif
        chk("rsp_valid", bus.rsp_valid, exp_rv);
        if (bus.rsp_valid && exp_q.size() > 0) begin
            e = exp_q[0];
            chk("rsp_data", bus.rsp_data, e.data);
            chk("rsp_misaligned", bus.rsp_misaligned, e.mal);
            chk("rsp_misaccess", bus.rsp_misaccess, e.mac);
        end
        popped = bus.rsp_valid && want_ready && exp_q.size() > 0;
        issued = drv_req && exp_q.size() < DEPTH;
        chk("mem_rd_en", bus.mem_rd_en, issued);
        if (issued) begin
            chk("mem_addr", bus.mem_addr, drv_addr - (drv_addr % 4));
            chk("mem_byte_en", bus.mem_byte_en, model_be(drv_size, int'(drv_addr % 4)));
            exp_q.push_back(model(drv_addr, drv_size, drv_sign, drv_rdata));
            mq_dat.push_back(drv_rdata);
            mq_cyc.push_back(cyc);
            n_issued++;
        end
        @(posedge clk);
        cyc++;
        if (mret) begin
            void'(mq_dat.pop_front());
            void'(mq_cyc.pop_front());
            n_ret++;
        end
        if (popped) begin
            void'(exp_q.pop_front());
            n_ret--;
        end
    endtask

    task automatic set_req(input logic [31:0] addr, input int size, input bit sign,
                           input logic [31:0] rdata);
        drv_req = 1'b1; drv_addr = addr; drv_size = size; drv_sign = sign; drv_rdata = rdata;
    endtask

    task automatic rand_req();
        set_req($urandom, int'($urandom_range(0, 3)), 1'($urandom), $urandom);
    endtask

    task automatic one_load(input logic [31:0] addr, input int size, input bit sign,
                            input logic [31:0] rdata);
        set_req(addr, size, sign, rdata);
        want_ret = 1'b1; want_ready = 1'b1;
        cycle();
        drv_req = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic drain();
        drv_req = 1'b0; want_ret = 1'b1; want_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) cycle();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; n_ret = 0; cyc = 0; n_issued = 0;
        drv_req = 0; drv_sign = 0; drv_addr = 0; drv_size = 0; drv_rdata = 0;
        want_ret = 0; want_ready = 0; stale = 0;
        bus.req_valid = 0; bus.req_access_size = 0; bus.req_sign = 0; bus.req_addr = 0;
        bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.rsp_ready = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_data", bus.rsp_data, 32'h0);
        chk("rst_flags", {bus.rsp_misaligned, bus.rsp_misaccess}, 2'b00);
        chk("rst_req_ready", bus.req_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases: signed/unsigned byte, half, misaligned half, word, invalid size.
        one_load(32'h1003, 1, 1'b1, 32'h80FF_1234);
        one_load(32'h1003, 1, 1'b0, 32'h80FF_1234);
        one_load(32'h2001, 2, 1'b0, 32'hAABE_EF55);
        one_load(32'h2003, 2, 1'b1, 32'hAABE_EF55);
        set_req(32'h3004, 3, 1'b0, 32'hDEAD_BEEF);
        cycle();
        set_req(32'h3008, 0, 1'b0, 32'h1234_5678);
        cycle();
        drain();

        // Fill with memory stalled, return all with the core stalled, then release.
        want_ret = 1'b0; want_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin rand_req(); cycle(); end
        drv_req = 1'b0; want_ret = 1'b1;
        repeat (DEPTH + 3) cycle();
        drain();

        // Back-to-back streaming across several pointer wraps.
        want_ret = 1'b1; want_ready = 1'b1;
        n_issued = 0;
        for (int i = 0; i < 200 && n_issued < 3 * DEPTH; i++) begin rand_req(); cycle(); end
        chk("stream_issued", n_issued, 3 * DEPTH);
        drain();

        // Fully random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) != 0) rand_req(); else drv_req = 1'b0;
            want_ret   = ($urandom_range(0, 2) != 0);
            want_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        drain();

        // Reset with two loads outstanding, one already presenting a response.
        want_ret = 1'b0; want_ready = 1'b0;
        rand_req(); cycle();
        rand_req(); cycle();
        drv_req = 1'b0; want_ret = 1'b1;
        cycle();
        want_ret = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("midrst_req_ready", bus.req_ready, 1'b1);
        exp_q.delete(); mq_dat.delete(); mq_cyc.delete(); n_ret = 0;
        @(negedge clk);
        rst = 1'b0;
        stale = 1'b1;
        cycle();
        stale = 1'b0;
        cycle();
        one_load(32'h4002, 2, 1'b1, 32'h8001_7FFF);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
